// File: rtl/mem_port_arbiter_pkg.sv
// Shared CPU types for the memory-port arbiter: FSM states, port owner and request command.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } mem_cmd_t;

  // Fixed-priority pick; only meaningful when at least one request is pending.
  function automatic owner_t pick_owner(input logic inst_req, input logic data_req,
                                        input logic data_prio);
    if (inst_req && data_req) return data_prio ? OWN_DATA : OWN_INST;
    return data_req ? OWN_DATA : OWN_INST;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store; one transaction outstanding, request->mem_req 1 cycle.
// Backpressure: addr_ok/data_ok are passed straight through from memory to the owning port only.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  arb_state_t state, state_nxt;
  owner_t     owner, owner_nxt;
  logic       any_req;
  mem_cmd_t   inst_cmd, data_cmd, sel_cmd;

  assign any_req  = inst_req | data_req;
  assign inst_cmd = '{wr: 1'b0, addr: inst_addr, wstrb: 4'h0, wdata: 32'h0};
  assign data_cmd = '{wr: data_wr, addr: data_addr, wstrb: data_wstrb, wdata: data_wdata};
  assign sel_cmd  = (owner == OWN_DATA) ? data_cmd : inst_cmd;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      owner <= OWN_INST;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  // Owner only moves at arbitration points, so a later higher-priority request waits its turn.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    unique case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_nxt = ST_ADDR;
          owner_nxt = pick_owner(inst_req, data_req, DATA_PRIO);
        end
      end
      ST_ADDR: begin
        if (mem_addr_ok) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (mem_data_ok) begin
          if (any_req) begin
            state_nxt = ST_ADDR;
            owner_nxt = pick_owner(inst_req, data_req, DATA_PRIO);
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = 32'h0;
    mem_wstrb    = 4'h0;
    mem_wdata    = 32'h0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = 32'h0;
    data_rdata   = 32'h0;
    unique case (state)
      ST_ADDR: begin
        mem_req   = 1'b1;
        mem_wr    = sel_cmd.wr;
        mem_addr  = sel_cmd.addr;
        mem_wstrb = sel_cmd.wstrb;
        mem_wdata = sel_cmd.wdata;
        if (owner == OWN_DATA) data_addr_ok = mem_addr_ok;
        else                   inst_addr_ok = mem_addr_ok;
      end
      ST_RESP: begin
        if (owner == OWN_DATA) begin
          data_data_ok = mem_data_ok;
          data_rdata   = mem_rdata;
        end else begin
          inst_data_ok = mem_data_ok;
          inst_rdata   = mem_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs driven 1ns after posedge, outputs sampled on negedge.
module tb_mem_port_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.DATA_PRIO(1'b1)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_addr = 0; data_wstrb = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  task automatic test_reset();
    resetn = 0;
    idle_inputs();
    inst_req = 1; inst_addr = 32'h1C00_0000; mem_data_ok = 1; mem_addr_ok = 1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    checks++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0) begin errors++; $display("FAIL reset_handshakes: got %b expected 0000", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
    checks++; if ({inst_rdata, data_rdata, mem_addr, mem_wdata} !== 128'h0) begin errors++; $display("FAIL reset_buses: got %h expected 0", {inst_rdata, data_rdata, mem_addr, mem_wdata}); end
    tick();
    resetn = 1;
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_inst_fetch();
    tick(); // cycle 0
    inst_req = 1; inst_addr = 32'h1C00_0000;
    data_wr = 1; data_wstrb = 4'hF; data_wdata = 32'hAAAA_5555; // idle data payload must not leak
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fetch_c0_mem_req: got %b expected 0", mem_req); end
    tick(); // cycle 1
    @(negedge clk);
    checks++; if ({mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata} !== {1'b1, 1'b0, 4'h0, 32'h1C00_0000, 32'h0}) begin errors++; $display("FAIL fetch_c1_cmd: got req=%b wr=%b strb=%h addr=%h wdata=%h expected 1 0 0 1c000000 0", mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata); end
    checks++; if (inst_addr_ok !== 1'b0) begin errors++; $display("FAIL fetch_c1_addr_ok: got %b expected 0", inst_addr_ok); end
    tick(); // cycle 2
    mem_addr_ok = 1;
    @(negedge clk);
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin errors++; $display("FAIL fetch_c2_addr_ok: got %b expected 10", {inst_addr_ok, data_addr_ok}); end
    tick(); // cycle 3
    inst_req = 0; mem_addr_ok = 0;
    @(negedge clk);
    checks++; if ({mem_req, inst_data_ok} !== 2'b00) begin errors++; $display("FAIL fetch_c3_resp_wait: got %b expected 00", {mem_req, inst_data_ok}); end
    tick(); // cycle 4
    mem_data_ok = 1; mem_rdata = 32'h0280_0C00;
    @(negedge clk);
    checks++; if ({inst_data_ok, inst_rdata} !== {1'b1, 32'h0280_0C00}) begin errors++; $display("FAIL fetch_c4_data: got ok=%b rdata=%h expected 1 02800c00", inst_data_ok, inst_rdata); end
    checks++; if ({data_data_ok, data_rdata} !== 33'h0) begin errors++; $display("FAIL fetch_c4_other_port: got ok=%b rdata=%h expected 0 0", data_data_ok, data_rdata); end
    tick(); // cycle 5
    idle_inputs();
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fetch_c5_idle: got %b expected 0", mem_req); end
  endtask

  task automatic test_simultaneous();
    tick(); // cycle 0
    inst_req = 1; inst_addr = 32'h1C00_0010;
    data_req = 1; data_wr = 0; data_addr = 32'h0000_0200;
    tick(); // cycle 1: data wins
    mem_addr_ok = 1;
    @(negedge clk);
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h0000_0200}) begin errors++; $display("FAIL prio_c1_addr: got req=%b addr=%h expected 1 00000200", mem_req, mem_addr); end
    checks++; if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin errors++; $display("FAIL prio_c1_addr_ok: got %b expected 10", {data_addr_ok, inst_addr_ok}); end
    tick(); // cycle 2: data response
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hCAFE_0001;
    @(negedge clk);
    checks++; if ({data_data_ok, data_rdata} !== {1'b1, 32'hCAFE_0001}) begin errors++; $display("FAIL prio_c2_data: got ok=%b rdata=%h expected 1 cafe0001", data_data_ok, data_rdata); end
    checks++; if ({inst_data_ok, inst_rdata} !== 33'h0) begin errors++; $display("FAIL prio_c2_inst_quiet: got ok=%b rdata=%h expected 0 0", inst_data_ok, inst_rdata); end
    tick(); // cycle 3: inst straight into ADDR
    mem_data_ok = 0; mem_rdata = 0; mem_addr_ok = 1;
    @(negedge clk);
    checks++; if ({mem_req, mem_addr, inst_addr_ok} !== {1'b1, 32'h1C00_0010, 1'b1}) begin errors++; $display("FAIL prio_c3_inst_addr: got req=%b addr=%h ok=%b expected 1 1c000010 1", mem_req, mem_addr, inst_addr_ok); end
    tick(); // cycle 4
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h0000_0013;
    @(negedge clk);
    checks++; if ({inst_data_ok, inst_rdata} !== {1'b1, 32'h0000_0013}) begin errors++; $display("FAIL prio_c4_inst_data: got ok=%b rdata=%h expected 1 00000013", inst_data_ok, inst_rdata); end
    tick();
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_store();
    tick(); // cycle 0
    data_req = 1; data_wr = 1; data_addr = 32'h0000_0080; data_wstrb = 4'hF; data_wdata = 32'h1234_5678;
    tick(); // cycle 1
    @(negedge clk);
    checks++; if ({mem_req, mem_wr, mem_wstrb, mem_wdata, mem_addr} !== {1'b1, 1'b1, 4'hF, 32'h1234_5678, 32'h0000_0080}) begin errors++; $display("FAIL store_cmd: got req=%b wr=%b strb=%h wdata=%h addr=%h expected 1 1 f 12345678 00000080", mem_req, mem_wr, mem_wstrb, mem_wdata, mem_addr); end
    mem_addr_ok = 1;
    @(posedge clk); #1; // cycle 2
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    @(negedge clk);
    checks++; if ({data_data_ok, inst_data_ok} !== 2'b10) begin errors++; $display("FAIL store_done: got %b expected 10", {data_data_ok, inst_data_ok}); end
    tick();
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_hold_owner();
    tick(); // cycle 0
    inst_req = 1; inst_addr = 32'h1C00_0020;
    tick(); // cycle 1: inst in ADDR, data arrives
    data_req = 1; data_wr = 0; data_addr = 32'h0000_0300;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++; if ({mem_addr, data_addr_ok, inst_addr_ok} !== {32'h1C00_0020, 2'b00}) begin errors++; $display("FAIL hold_c%0d: got addr=%h dok=%b iok=%b expected 1c000020 0 0", c, mem_addr, data_addr_ok, inst_addr_ok); end
      if (c < 3) tick();
    end
    tick(); // cycle 4
    mem_addr_ok = 1;
    @(negedge clk);
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin errors++; $display("FAIL hold_c4_addr_ok: got %b expected 10", {inst_addr_ok, data_addr_ok}); end
    tick(); // cycle 5
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h0000_0777;
    @(negedge clk);
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin errors++; $display("FAIL hold_c5_data_ok: got %b expected 10", {inst_data_ok, data_data_ok}); end
    tick(); // cycle 6: data served next
    mem_data_ok = 0; mem_rdata = 0; mem_addr_ok = 1;
    @(negedge clk);
    checks++; if ({mem_addr, data_addr_ok} !== {32'h0000_0300, 1'b1}) begin errors++; $display("FAIL hold_c6_data_addr: got addr=%h ok=%b expected 00000300 1", mem_addr, data_addr_ok); end
    tick(); // cycle 7
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    @(negedge clk);
    checks++; if (data_data_ok !== 1'b1) begin errors++; $display("FAIL hold_c7_data_ok: got %b expected 1", data_data_ok); end
    tick();
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset_in_resp();
    tick(); // cycle 0
    inst_req = 1; inst_addr = 32'h1C00_0040;
    tick(); // cycle 1
    mem_addr_ok = 1;
    tick(); // cycle 2: RESP, reset hits
    inst_req = 0; mem_addr_ok = 0; resetn = 0;
    @(negedge clk);
    checks++; if ({mem_req, inst_addr_ok, inst_data_ok, data_data_ok} !== 4'b0) begin errors++; $display("FAIL rst_resp_outputs: got %b expected 0000", {mem_req, inst_addr_ok, inst_data_ok, data_data_ok}); end
    tick(); // cycle 3: late response
    resetn = 1; mem_data_ok = 1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++; $display("FAIL rst_late_data_ok: got %b expected 00", {inst_data_ok, data_data_ok}); end
    checks++; if ({inst_rdata, data_rdata} !== 64'h0) begin errors++; $display("FAIL rst_late_rdata: got %h expected 0", {inst_rdata, data_rdata}); end
    tick(); // cycle 4: fresh request from IDLE
    mem_data_ok = 0; mem_rdata = 0; data_req = 1; data_addr = 32'h0000_0400;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_idle_c4: got %b expected 0", mem_req); end
    tick(); // cycle 5
    mem_addr_ok = 1;
    @(negedge clk);
    checks++; if ({mem_req, mem_addr, data_addr_ok} !== {1'b1, 32'h0000_0400, 1'b1}) begin errors++; $display("FAIL rst_idle_c5: got req=%b addr=%h ok=%b expected 1 00000400 1", mem_req, mem_addr, data_addr_ok); end
    tick(); // cycle 6
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    tick();
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_spurious();
    tick();
    mem_data_ok = 1; mem_addr_ok = 1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    checks++; if ({inst_data_ok, data_data_ok, inst_addr_ok, data_addr_ok} !== 4'b0) begin errors++; $display("FAIL spurious_ok: got %b expected 0000", {inst_data_ok, data_data_ok, inst_addr_ok, data_addr_ok}); end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++; if ({mem_req, inst_data_ok, data_data_ok} !== 3'b0) begin errors++; $display("FAIL spurious_after: got %b expected 000", {mem_req, inst_data_ok, data_data_ok}); end
  endtask

  initial begin
    test_reset();
    test_inst_fetch();
    test_simultaneous();
    test_store();
    test_hold_owner();
    test_reset_in_resp();
    test_spurious();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
